mc_cpu: RTL and testbench
=========================

MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_ON_ILLEGAL, default 0: 0 means an illegal opcode halts the core; 1 means it retires as a no-op.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 mem_req  output  1  memory transaction request.
REQ-006 mem_we  output  1  1 = store, 0 = load/fetch; valid while mem_req=1.
REQ-007 mem_addr  output  32  byte address; word aligned.
REQ-008 mem_wdata  output  32  store data.
REQ-009 mem_rdata  input  32  read data, valid in the cycle mem_ack=1.
REQ-010 mem_ack  input  1  transaction completes at the rising edge where mem_req=1 and mem_ack=1.
REQ-011 retire  output  1  one-cycle pulse, one instruction completed.
REQ-012 halted  output  1  core stopped on an illegal opcode.
REQ-013 pc_dbg  output  32  PC of the instruction currently executing.

Function
REQ-014 Unified memory for instructions and data; multi-cycle FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-015 Supported ops: R-type add, sub, and, or, slt (opcode 0; funct 0x20, 0x22, 0x24, 0x25, 0x2A); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=PC; hold until ack; on ack latch IR, PC<=PC+4, go to DECODE.
REQ-017 DECODE: latch A=R[rs], B=R[rt], sign-extended imm; j sets PC={PC[31:28],IR[25:0],2'b00}, pulses retire, goes to FETCH.
REQ-018 EXEC: ALU result latched; beq compares A==B, if equal PC<=PC+(simm<<2) (PC already +4), retire, go to FETCH; lw/sw go to MEM; others go to WB.
REQ-019 MEM: mem_req=1, mem_addr=A+simm, mem_we=1 for sw with mem_wdata=B; hold until ack; sw retires and goes to FETCH; lw latches mem_rdata and goes to WB.
REQ-020 WB: write result to rd (R-type) or rt (addi/lw), pulse retire, go to FETCH.
REQ-021 Register 0 always reads 0; writes to it are discarded.
REQ-022 Arithmetic is 32-bit wrap-around, no overflow trap; slt is signed.
REQ-023 Cycle counts with zero-wait ack: j 2, beq 3, sw 4, R-type/addi 4, lw 5; each wait cycle adds one.
REQ-024 mem_addr, mem_we and mem_wdata are stable while mem_req=1 and ack is low.
REQ-025 Unsupported opcode/funct with NOP_ON_ILLEGAL=0: in DECODE go to HALT; halted=1, mem_req=0 until reset. With NOP_ON_ILLEGAL=1: retire in DECODE, no state change except PC.
REQ-026 mem_ack while mem_req=0 is ignored.
REQ-027 Register file: 32x32, 2 read ports, 1 write port; no bypass is needed, because the FSM has no overlap.

Reset
REQ-028 When rst=1 at an edge: state<=FETCH, PC<=RESET_PC, all 32 registers<=0, IR/A/B/ALU latches<=0.
REQ-029 Outputs during and right after reset: mem_req=1 (FETCH), mem_we=0, mem_addr=RESET_PC, retire=0, halted=0.
REQ-030 Reset during a pending transaction aborts it; an ack in the reset cycle is discarded.
REQ-031 Reset clears HALT.

Verification
REQ-032 Zero-wait memory with addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> R3=12, retire pulses at cycles 4, 8, 12 after reset release.
REQ-033 sw $3,0x40($0); lw $4,0x40($0) -> store shows mem_we=1, addr 0x40, wdata 12; R4=12; lw takes 5 cycles.
REQ-034 beq $1,$1,-1 -> branches back to itself, PC repeats every 3 cycles; beq with unequal operands falls through to PC+4.
REQ-035 Ack delayed 3 cycles on every transaction -> results identical; add takes 7 cycles; request signals held stable.
REQ-036 Opcode 0x3F with NOP_ON_ILLEGAL=0 -> halted=1, mem_req=0; rst pulse -> fetch resumes at RESET_PC, halted=0.
REQ-037 addi $0,$0,9 then add $5,$0,$0 -> R5=0; and with 0x7FFFFFFF+1 via add -> 0x80000000, no trap.

Source files
------------

// File: rtl/mc_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : mc_cpu
//  Description : Multi-cycle 32-bit MIPS-subset core on a unified memory
//                port. FSM: FETCH, DECODE, EXEC, MEM, WB, HALT.
//                Ops: add/sub/and/or/slt, addi, lw, sw, beq, j.
//  Ports       : clk, rst          clock / synchronous active-high reset
//                mem_req, mem_we   request strobe, 1 = store
//                mem_addr          byte address (fetch PC or A+simm)
//                mem_wdata         store data (B operand)
//                mem_rdata/mem_ack read data / completion handshake
//                retire            one-cycle pulse per completed instruction
//                halted            core stopped on an illegal opcode
//                pc_dbg            PC of the instruction being executed
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_cpu #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter bit          NOP_ON_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        retire,
    output logic        halted,
    output logic [31:0] pc_dbg
);

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_pc;      // next fetch address (already +4 after fetch)
    logic [31:0] r_ipc;     // address of the instruction in flight
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_alu;     // ALU result; also holds load data for WB
    logic [31:0] r_regs [0:31];

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_simm;
    logic [4:0]  w_wr_idx;
    logic        w_legal;
    logic [31:0] w_alu_r;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_funct  = r_ir[5:0];
    assign w_simm   = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_wr_idx = (w_op == c_OP_RTYPE) ? w_rd : w_rt;

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            c_OP_RTYPE: w_legal = (w_funct == c_FN_ADD) || (w_funct == c_FN_SUB) ||
                                  (w_funct == c_FN_AND) || (w_funct == c_FN_OR)  ||
                                  (w_funct == c_FN_SLT);
            c_OP_J, c_OP_BEQ, c_OP_ADDI, c_OP_LW, c_OP_SW: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_r = '0;
        case (w_funct)
            c_FN_ADD: w_alu_r = r_a + r_b;
            c_FN_SUB: w_alu_r = r_a - r_b;
            c_FN_AND: w_alu_r = r_a & r_b;
            c_FN_OR:  w_alu_r = r_a | r_b;
            c_FN_SLT: w_alu_r = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
            default:  w_alu_r = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and memory/retire outputs
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = r_pc;
        mem_wdata    = r_b;
        retire       = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_next_state = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                if (!w_legal) begin
                    if (NOP_ON_ILLEGAL) begin
                        retire       = 1'b1;
                        w_next_state = c_ST_FETCH;
                    end else begin
                        w_next_state = c_ST_HALT;
                    end
                end else if (w_op == c_OP_J) begin
                    retire       = 1'b1;
                    w_next_state = c_ST_FETCH;
                end else begin
                    w_next_state = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                if (w_op == c_OP_BEQ) begin
                    retire       = 1'b1;
                    w_next_state = c_ST_FETCH;
                end else if ((w_op == c_OP_LW) || (w_op == c_OP_SW)) begin
                    w_next_state = c_ST_MEM;
                end else begin
                    w_next_state = c_ST_WB;
                end
            end
            c_ST_MEM: begin
                // Address comes from the latched ALU result so it cannot
                // move while the request waits for an ack.
                mem_req  = 1'b1;
                mem_addr = r_alu;
                mem_we   = (w_op == c_OP_SW);
                if (mem_ack) begin
                    if (w_op == c_OP_SW) begin
                        retire       = 1'b1;
                        w_next_state = c_ST_FETCH;
                    end else begin
                        w_next_state = c_ST_WB;
                    end
                end
            end
            c_ST_WB: begin
                retire       = 1'b1;
                w_next_state = c_ST_FETCH;
            end
            c_ST_HALT: begin
                w_next_state = c_ST_HALT;
            end
            default: begin
                w_next_state = c_ST_FETCH;
            end
        endcase
    end

    assign halted = (r_state == c_ST_HALT);
    assign pc_dbg = (r_state == c_ST_FETCH) ? r_pc : r_ipc;

    // Datapath latches and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_PC;
            r_ipc <= RESET_PC;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_imm <= '0;
            r_alu <= '0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (mem_ack) begin
                        r_ir  <= mem_rdata;
                        r_ipc <= r_pc;
                        r_pc  <= r_pc + 32'd4;
                    end
                end
                c_ST_DECODE: begin
                    // r_regs[0] is never written, so it always reads zero.
                    r_a   <= r_regs[w_rs];
                    r_b   <= r_regs[w_rt];
                    r_imm <= w_simm;
                    if (w_legal && (w_op == c_OP_J)) begin
                        r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    end
                end
                c_ST_EXEC: begin
                    if (w_op == c_OP_RTYPE) begin
                        r_alu <= w_alu_r;
                    end else begin
                        r_alu <= r_a + r_imm;
                    end
                    // r_pc already points past the branch.
                    if ((w_op == c_OP_BEQ) && (r_a == r_b)) begin
                        r_pc <= r_pc + {r_imm[29:0], 2'b00};
                    end
                end
                c_ST_MEM: begin
                    if (mem_ack && (w_op == c_OP_LW)) begin
                        r_alu <= mem_rdata;
                    end
                end
                c_ST_WB: begin
                    if (w_wr_idx != 5'd0) begin
                        r_regs[w_wr_idx] <= r_alu;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_cpu
//  Description : Scoreboard bench for mc_cpu. An instruction-level model
//                predicts each retirement (PC, cycle cost) and each store;
//                a monitor compares them against the DUT as they occur.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_cpu;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        retire;
    logic        halted;
    logic [31:0] pc_dbg;

    mc_cpu #(.RESET_PC(32'h0000_0000), .NOP_ON_ILLEGAL(1'b0)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .retire(retire), .halted(halted), .pc_dbg(pc_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; int cyc; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

    int          n_checks;
    int          n_fail;
    int          n_ret_seen;
    logic [31:0] mem [0:1023];   // memory served to the DUT
    logic [31:0] img [0:1023];   // program/data image shared with the model
    int          dly [0:4095];   // wait cycles per transaction index
    ret_t        ret_q[$];
    st_t         st_q[$];

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rt, input int rs, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int word_idx);
        return {6'h02, 26'(word_idx)};
    endfunction

    // Instruction-level reference: architectural effect plus cycle cost
    // (fetch 1, decode 1, exec 1, mem 1, wb 1, plus each wait cycle).
    task automatic model(input int max_inst, output bit halts);
        logic [31:0] r [0:31];
        logic [31:0] m [0:1023];
        logic [31:0] pc, npc, ir, simm, a, b, res, addr;
        logic [5:0]  op, fn;
        int          t, cyc, wr;
        ret_t        re;
        st_t         se;
        m = img;
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        pc = 32'd0; t = 0; halts = 1'b0;
        for (int k = 0; k < max_inst; k++) begin
            ir = m[pc[11:2]];
            cyc = 1 + dly[t]; t++;
            npc = pc + 32'd4;
            op = ir[31:26]; fn = ir[5:0];
            a = r[ir[25:21]]; b = r[ir[20:16]];
            simm = {{16{ir[15]}}, ir[15:0]};
            wr = -1; res = 32'd0;
            case (op)
                6'h02: begin cyc += 1; npc = {npc[31:28], ir[25:0], 2'b00}; end
                6'h04: begin cyc += 2; if (a == b) npc = npc + (simm << 2); end
                6'h08: begin cyc += 3; wr = int'(ir[20:16]); res = a + simm; end
                6'h23: begin
                    cyc += 4 + dly[t]; t++;
                    addr = a + simm; wr = int'(ir[20:16]); res = m[addr[11:2]];
                end
                6'h2B: begin
                    cyc += 3 + dly[t]; t++;
                    addr = a + simm; m[addr[11:2]] = b;
                    se.addr = addr; se.data = b; st_q.push_back(se);
                end
                6'h00: begin
                    cyc += 3; wr = int'(ir[15:11]);
                    case (fn)
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: halts = 1'b1;
                    endcase
                end
                default: halts = 1'b1;
            endcase
            if (halts) break;
            if (wr > 0) r[wr] = res;
            re.pc = pc; re.cyc = cyc; ret_q.push_back(re);
            pc = npc;
        end
    endtask

    // Memory responder: inputs change 2 time units after the rising edge.
    initial begin : responder
        int cnt, txn;
        cnt = 0; txn = 0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                mem_ack = 1'($urandom_range(0, 1));   // must be ignored
                mem_rdata = $urandom; cnt = 0; txn = 0;
            end else if (mem_req) begin
                if (cnt >= dly[txn]) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr[11:2]];
                    if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                    if (txn < 4095) txn++;
                    cnt = 0;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom; cnt++;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));   // stray ack, must be ignored
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: samples on the falling edge, pops expectations.
    initial begin : monitor
        int          n;
        logic        pend, p_we;
        logic [31:0] p_addr, p_wdata;
        ret_t        e;
        st_t         s;
        n = 0; pend = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n = 0; pend = 1'b0;
            end else begin
                n++;
                if (pend) begin
                    check(mem_req === 1'b1 && mem_addr === p_addr && mem_we === p_we &&
                          (!p_we || mem_wdata === p_wdata), "req_stable", mem_addr, p_addr);
                end
                if (retire === 1'b1) begin
                    if (ret_q.size() == 0) begin
                        check(1'b0, "retire_extra", pc_dbg, 32'd0);
                    end else begin
                        e = ret_q.pop_front();
                        check(pc_dbg === e.pc, "retire_pc", pc_dbg, e.pc);
                        check(n == e.cyc, "retire_cycles", n, e.cyc);
                    end
                    n_ret_seen++;
                    n = 0;
                end
                if (mem_req && mem_we && mem_ack) begin
                    if (st_q.size() == 0) begin
                        check(1'b0, "store_extra", mem_addr, 32'd0);
                    end else begin
                        s = st_q.pop_front();
                        check(mem_addr === s.addr, "store_addr", mem_addr, s.addr);
                        check(mem_wdata === s.data, "store_data", mem_wdata, s.data);
                    end
                end
                pend = mem_req && !mem_ack;
                p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
            end
        end
    end

    // mode 0: zero-wait, 1: three waits every transaction, 2: random 0..3
    task automatic run(input int max_inst, input int mode);
        bit halts;
        int n_exp, guard;
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 4096; i++)
            dly[i] = (mode == 0) ? 0 : (mode == 1) ? 3 : int'($urandom_range(0, 3));
        for (int i = 0; i < 1024; i++) mem[i] = img[i];
        ret_q.delete(); st_q.delete();
        model(max_inst, halts);
        n_exp = ret_q.size();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(mem_req === 1'b1, "rst_mem_req", 32'(mem_req), 32'd1);
        check(mem_we === 1'b0, "rst_mem_we", 32'(mem_we), 32'd0);
        check(mem_addr === 32'd0, "rst_mem_addr", mem_addr, 32'd0);
        check(retire === 1'b0 && halted === 1'b0, "rst_retire_halted",
              {30'd0, retire, halted}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        n_ret_seen = 0;
        guard = 0;
        while (n_ret_seen < n_exp && guard < 5000) begin
            @(negedge clk); guard++;
        end
        check(guard < 5000, "retire_timeout", n_ret_seen, n_exp);
        if (halts) begin
            repeat (6) @(negedge clk);
            check(halted === 1'b1, "halted", 32'(halted), 32'd1);
            check(mem_req === 1'b0, "halt_no_req", 32'(mem_req), 32'd0);
        end
        check(st_q.size() == 0, "stores_pending", st_q.size(), 32'd0);
    endtask

    task automatic build_directed();
        for (int i = 0; i < 1024; i++) img[i] = $urandom;
        img[0]  = enc_i(8, 1, 0, 5);           // addi $1,$0,5
        img[1]  = enc_i(8, 2, 0, 7);           // addi $2,$0,7
        img[2]  = enc_r(8'h20, 3, 1, 2);       // add  $3,$1,$2
        img[3]  = enc_i(8'h2B, 3, 0, 8'h40);   // sw   $3,0x40($0)
        img[4]  = enc_i(8'h23, 4, 0, 8'h40);   // lw   $4,0x40($0)
        img[5]  = enc_i(8, 0, 0, 9);           // addi $0,$0,9
        img[6]  = enc_r(8'h20, 5, 0, 0);       // add  $5,$0,$0
        img[7]  = enc_i(8'h23, 6, 0, 8'h44);   // lw   $6,0x44($0)
        img[8]  = enc_i(8, 7, 0, 1);           // addi $7,$0,1
        img[9]  = enc_r(8'h20, 7, 6, 7);       // add  $7,$6,$7
        img[10] = enc_i(4, 2, 1, 5);           // beq  $1,$2,+5 (not taken)
        img[11] = enc_i(8'h2B, 4, 0, 12'h200); // sw   $4,0x200
        img[12] = enc_i(8'h2B, 5, 0, 12'h204); // sw   $5,0x204
        img[13] = enc_i(8'h2B, 7, 0, 12'h208); // sw   $7,0x208
        img[14] = enc_r(8'h2A, 8, 7, 1);       // slt  $8,$7,$1
        img[15] = enc_j(64);                   // j    0x100
        img[17] = 32'h7FFF_FFFF;               // data at 0x44
        img[64] = enc_i(8'h2B, 8, 0, 12'h20C); // sw   $8,0x20C
        img[65] = 32'hFC00_0000;               // opcode 0x3F
    endtask

    task automatic check_directed();
        check(mem[16]  === 32'd12, "dir_store_r3", mem[16], 32'd12);
        check(mem[128] === 32'd12, "dir_r4", mem[128], 32'd12);
        check(mem[129] === 32'd0, "dir_r5", mem[129], 32'd0);
        check(mem[130] === 32'h8000_0000, "dir_r7_wrap", mem[130], 32'h8000_0000);
        check(mem[131] === 32'd1, "dir_slt_signed", mem[131], 32'd1);
    endtask

    task automatic gen_random(input int n);
        int sel, off;
        int fl [5];
        fl[0] = 8'h20; fl[1] = 8'h22; fl[2] = 8'h24; fl[3] = 8'h25; fl[4] = 8'h2A;
        for (int i = 0; i < 1024; i++) img[i] = $urandom;
        for (int i = 0; i < n; i++) begin
            sel = int'($urandom_range(0, 99));
            off = int'($urandom_range(0, 3));
            if (sel < 40)
                img[i] = enc_r(fl[$urandom_range(0, 4)], int'($urandom_range(0, 7)),
                               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            else if (sel < 60)
                img[i] = enc_i(8, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                               int'($urandom_range(0, 65535)));
            else if (sel < 70)
                img[i] = enc_i(8'h23, int'($urandom_range(0, 7)), 0,
                               12'h800 + 4 * int'($urandom_range(0, 63)));
            else if (sel < 80)
                img[i] = enc_i(8'h2B, int'($urandom_range(0, 7)), 0,
                               12'h800 + 4 * int'($urandom_range(0, 63)));
            else if (sel < 94)
                img[i] = enc_i(4, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), off);
            else
                img[i] = enc_j(i + 1 + off);
        end
        for (int k = 1; k < 8; k++) img[n + k - 1] = enc_i(8'h2B, k, 0, 12'hF00 + 4 * k);
        img[n + 7] = 32'hFC00_0000;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        n_checks = 0; n_fail = 0; n_ret_seen = 0;
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
        build_directed(); run(1000, 0); check_directed();
        build_directed(); run(1000, 1); check_directed();
        // beq $1,$1,-1 spins on itself; reset is applied mid-loop.
        for (int i = 0; i < 1024; i++) img[i] = $urandom;
        img[0] = enc_i(8, 1, 0, 5);
        img[1] = enc_i(4, 1, 1, -1);
        run(8, 2);
        for (int k = 0; k < 4; k++) begin
            gen_random(40);
            run(1000, 2);
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(halted === 1'b0 && mem_req === 1'b1 && mem_addr === 32'd0, "final_reset_resume",
              mem_addr, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
